// File: rtl/seq_normalizer.sv
// rtl/seq_normalizer.sv - multi-cycle FPU post-add normaliser; optional NORM_FAST_EN selects single-cycle LZC shifting
module seq_normalizer #(
    parameter int N_mant = 25,
    parameter int N_exp  = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_mant-1:0] mantissa_in,
    input  logic [N_exp-1:0]  expoente_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_mant-2:0] mantissa_out,
    output logic              mantissa_lsb,
    output logic [N_exp-1:0]  expoente_out,
    output logic              zero,
    output logic              overflow,
    output logic              underflow,
    output logic [CNT_W-1:0]  shift_count
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [N_exp-1:0] EXP_MAX = '1;

    state_t            state, state_nxt;
    logic [N_mant-1:0] work, work_nxt;
    logic [N_exp-1:0]  exp_r, exp_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              lsb_r, lsb_nxt;
    logic              zero_r, zero_nxt;
    logic              ovf_r, ovf_nxt;
    logic              unf_r, unf_nxt;

`ifdef NORM_FAST_EN
    localparam int LW = N_exp + CNT_W;

    logic [LW-1:0] lzc_w, em1_w, k_w;

    // Leading-zero count below the carry bit, limited so the exponent never drops under 1
    always_comb begin
        lzc_w = '0;
        for (int i = 0; i < N_mant - 1; i++) begin
            if (work[i]) lzc_w = LW'(N_mant - 2 - i);
        end
        em1_w = LW'(exp_r) - LW'(1);
        k_w   = (lzc_w < em1_w) ? lzc_w : em1_w;
    end
`endif

    // State and working registers; reset discards any operand in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            exp_r  <= '0;
            cnt    <= '0;
            lsb_r  <= 1'b0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            state  <= state_nxt;
            work   <= work_nxt;
            exp_r  <= exp_nxt;
            cnt    <= cnt_nxt;
            lsb_r  <= lsb_nxt;
            zero_r <= zero_nxt;
            ovf_r  <= ovf_nxt;
            unf_r  <= unf_nxt;
        end
    end

    // Next state and datapath: first matching normalisation rule wins each SHIFT cycle
    always_comb begin
        state_nxt = state;
        work_nxt  = work;
        exp_nxt   = exp_r;
        cnt_nxt   = cnt;
        lsb_nxt   = lsb_r;
        zero_nxt  = zero_r;
        ovf_nxt   = ovf_r;
        unf_nxt   = unf_r;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    work_nxt  = mantissa_in;
                    exp_nxt   = expoente_in;
                    cnt_nxt   = '0;
                    lsb_nxt   = 1'b0;
                    zero_nxt  = 1'b0;
                    ovf_nxt   = 1'b0;
                    unf_nxt   = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (work == '0) begin
                    exp_nxt   = '0;
                    zero_nxt  = 1'b1;
                    state_nxt = DONE;
                end else if (work[N_mant-1]) begin
                    work_nxt  = {1'b0, work[N_mant-1:1]};
                    lsb_nxt   = work[0];
                    exp_nxt   = (exp_r == EXP_MAX) ? EXP_MAX : exp_r + N_exp'(1);
                    ovf_nxt   = (exp_nxt == EXP_MAX);
                    state_nxt = DONE;
                end else if (work[N_mant-2]) begin
                    state_nxt = DONE;
                end else if (exp_r <= N_exp'(1)) begin
                    unf_nxt   = 1'b1;
                    state_nxt = DONE;
                end else begin
`ifdef NORM_FAST_EN
                    // Whole shift at once; a clamped shift leaves the hidden bit clear
                    work_nxt  = work << k_w;
                    exp_nxt   = exp_r - k_w[N_exp-1:0];
                    cnt_nxt   = k_w[CNT_W-1:0];
                    unf_nxt   = (k_w != lzc_w);
                    state_nxt = DONE;
`else
                    work_nxt  = work << 1;
                    exp_nxt   = exp_r - N_exp'(1);
                    cnt_nxt   = cnt + CNT_W'(1);
`endif
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready     = (state == IDLE);
    assign out_valid    = (state == DONE);
    assign mantissa_out = work[N_mant-2:0];
    assign mantissa_lsb = lsb_r;
    assign expoente_out = exp_r;
    assign zero         = zero_r;
    assign overflow     = ovf_r;
    assign underflow    = unf_r;
    assign shift_count  = cnt;

endmodule
